// File: rtl/pump_command_ui_if.sv
// Front-panel bundle: raw active-low buttons in, selections and
// single-cycle pump commands out.
interface pump_command_ui_if;
   logic       btn_next_n;
   logic       btn_field_n;
   logic       btn_start_n;
   logic       btn_stop_n;
   logic       btn_manual_n;
   logic [1:0] fragrance_select;
   logic [1:0] timer_select;
   logic       pump_on;
   logic       pump_off;
   logic       manual_on;
   logic       running;
   logic       edit_field;

   modport master (
      output btn_next_n, btn_field_n, btn_start_n,
      output btn_stop_n, btn_manual_n,
      input  fragrance_select, timer_select,
      input  pump_on, pump_off, manual_on,
      input  running, edit_field
   );

   modport slave (
      input  btn_next_n, btn_field_n, btn_start_n,
      input  btn_stop_n, btn_manual_n,
      output fragrance_select, timer_select,
      output pump_on, pump_off, manual_on,
      output running, edit_field
   );
endinterface

// File: rtl/pump_command_ui.sv
// Front-panel command generator: per-button sync + debounce, press
// arbitration and an IDLE/RUN FSM producing single-cycle pump commands.
module pump_command_ui #(
   parameter int CLOCK_FREQ  = 1_000_000,
   parameter int DEBOUNCE_MS = 20
) (
   input logic              clk,
   input logic              rst_n,
   pump_command_ui_if.slave io
);
   localparam int DC_RAW = CLOCK_FREQ / 1000 * DEBOUNCE_MS;
   localparam int DEBOUNCE_CYCLES = (DC_RAW < 2) ? 2 : DC_RAW;
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   // Bit order everywhere: {manual, stop, start, field, next}
   logic [4:0]    w_raw;
   logic [4:0]    r_s1;
   logic [4:0]    r_s2;
   logic [4:0]    r_deb;
   logic [4:0]    r_deb_d;
   logic [CW-1:0] r_cnt [5];
   logic [4:0]    w_press;

   state_t        r_state;
   logic [1:0]    r_frag;
   logic [1:0]    r_tim;
   logic          r_field;
   logic          r_on;
   logic          r_off;
   logic          r_man;
   logic          r_run;

   assign w_raw = {io.btn_manual_n, io.btn_stop_n, io.btn_start_n,
                   io.btn_field_n, io.btn_next_n};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1    <= '1;
         r_s2    <= '1;
         r_deb   <= '1;
         r_deb_d <= '1;
         for (int i = 0; i < 5; i++) r_cnt[i] <= '0;
      end else begin
         r_s1    <= w_raw;
         r_s2    <= r_s1;
         r_deb_d <= r_deb;
         for (int i = 0; i < 5; i++) begin
            if (r_s2[i] == r_deb[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_LAST) begin
               r_deb[i] <= r_s2[i];
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CW'(1);
            end
         end
      end
   end

   // Falling edge of the debounced level only; release is silent.
   assign w_press = r_deb_d & ~r_deb;

   function automatic logic [1:0] f_wrap_inc(input logic [1:0] v);
      return (v >= 2'd2) ? 2'd0 : v + 2'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_frag  <= 2'd0;
         r_tim   <= 2'd0;
         r_field <= 1'b0;
         r_on    <= 1'b0;
         r_off   <= 1'b0;
         r_man   <= 1'b0;
         r_run   <= 1'b0;
      end else begin
         r_on  <= 1'b0;
         r_off <= 1'b0;
         r_man <= 1'b0;
         // Only the highest-priority strobe acts; the rest are dropped.
         priority case (1'b1)
            w_press[3]: begin
               r_off   <= 1'b1;
               r_state <= S_IDLE;
               r_run   <= 1'b0;
            end
            w_press[2]: begin
               if (r_state == S_IDLE) begin
                  r_on    <= 1'b1;
                  r_state <= S_RUN;
                  r_run   <= 1'b1;
               end
            end
            w_press[4]: r_man <= 1'b1;
            w_press[1]: begin
               if (r_state == S_IDLE) r_field <= ~r_field;
            end
            w_press[0]: begin
               if (r_state == S_IDLE) begin
                  if (r_field) r_tim  <= f_wrap_inc(r_tim);
                  else         r_frag <= f_wrap_inc(r_frag);
               end
            end
            default: ;
         endcase
      end
   end

   assign io.fragrance_select = r_frag;
   assign io.timer_select     = r_tim;
   assign io.edit_field       = r_field;
   assign io.pump_on          = r_on;
   assign io.pump_off         = r_off;
   assign io.manual_on        = r_man;
   assign io.running          = r_run;
endmodule

// File: tb/tb_pump_command_ui.sv
// Self-checking bench for pump_command_ui with a rule-level model and
// randomized button presses (DEBOUNCE_CYCLES = 5, press latency 8).
module tb_pump_command_ui;
   localparam logic [4:0] B_NEXT  = 5'b00001;
   localparam logic [4:0] B_FIELD = 5'b00010;
   localparam logic [4:0] B_START = 5'b00100;
   localparam logic [4:0] B_STOP  = 5'b01000;
   localparam logic [4:0] B_MAN   = 5'b10000;
   localparam int LAT = 8;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   int g_on, g_off, g_man, g_lat, g_multi, g_selpulse;

   pump_command_ui_if u_if ();

   pump_command_ui #(
      .CLOCK_FREQ (1000),
      .DEBOUNCE_MS(5)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .io   (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_btn(input logic [4:0] m);
      u_if.btn_next_n   = ~m[0];
      u_if.btn_field_n  = ~m[1];
      u_if.btn_start_n  = ~m[2];
      u_if.btn_stop_n   = ~m[3];
      u_if.btn_manual_n = ~m[4];
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      set_btn(5'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Hold the masked buttons low for 'hold' sampling edges, then watch
   // until both press and release have settled.
   task automatic press(input logic [4:0] m, input int hold);
      logic [1:0] pf, pt;
      bit chg, chg_prev;
      int np;
      g_on = 0; g_off = 0; g_man = 0;
      g_lat = -1; g_multi = 0; g_selpulse = 0;
      @(negedge clk);
      pf = u_if.fragrance_select;
      pt = u_if.timer_select;
      chg_prev = 1'b0;
      set_btn(m);
      for (int c = 1; c <= hold + 16; c++) begin
         @(negedge clk);
         np = int'(u_if.pump_on) + int'(u_if.pump_off)
            + int'(u_if.manual_on);
         chg = (u_if.fragrance_select !== pf)
            || (u_if.timer_select !== pt);
         pf = u_if.fragrance_select;
         pt = u_if.timer_select;
         if (np > 1) g_multi++;
         if (np > 0 && (chg || chg_prev)) g_selpulse++;
         if (np > 0 && g_lat < 0) g_lat = c;
         g_on  += int'(u_if.pump_on);
         g_off += int'(u_if.pump_off);
         g_man += int'(u_if.manual_on);
         chg_prev = chg;
         if (c == hold) set_btn(5'b0);
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (u_if.fragrance_select !== 2'd0) begin
         n_err++;
         $display("FAIL reset_frag: got %0d want 0", u_if.fragrance_select);
      end
      n_cmp++;
      if (u_if.timer_select !== 2'd0) begin
         n_err++;
         $display("FAIL reset_timer: got %0d want 0", u_if.timer_select);
      end
      n_cmp++;
      if ({u_if.edit_field, u_if.running} !== 2'b00) begin
         n_err++;
         $display("FAIL reset_field_run: got %b%b want 00",
                  u_if.edit_field, u_if.running);
      end
      n_cmp++;
      if ({u_if.pump_on, u_if.pump_off, u_if.manual_on} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_pulses: got %b%b%b want 000",
                  u_if.pump_on, u_if.pump_off, u_if.manual_on);
      end
   endtask

   task automatic test_debounce();
      do_reset();
      press(B_START, 4);
      n_cmp++;
      if (g_on !== 0 || u_if.running !== 1'b0) begin
         n_err++;
         $display("FAIL glitch_start: pump_on=%0d running=%b want 0 0",
                  g_on, u_if.running);
      end
      press(B_START, 20);
      n_cmp++;
      if (g_on !== 1) begin
         n_err++;
         $display("FAIL start_count: got %0d want 1", g_on);
      end
      n_cmp++;
      if (g_lat !== LAT) begin
         n_err++;
         $display("FAIL start_latency: got %0d want %0d", g_lat, LAT);
      end
      n_cmp++;
      if (u_if.running !== 1'b1) begin
         n_err++;
         $display("FAIL start_running: got %b want 1", u_if.running);
      end
   endtask

   task automatic test_wrap();
      logic [1:0] exp_f [4];
      int tot;
      exp_f[0] = 2'd1; exp_f[1] = 2'd2; exp_f[2] = 2'd0; exp_f[3] = 2'd1;
      tot = 0;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         press(B_NEXT, 20);
         tot += g_on + g_off + g_man;
         n_cmp++;
         if (u_if.fragrance_select !== exp_f[i]) begin
            n_err++;
            $display("FAIL wrap_frag%0d: got %0d want %0d", i,
                     u_if.fragrance_select, exp_f[i]);
         end
      end
      press(B_FIELD, 20);
      tot += g_on + g_off + g_man;
      n_cmp++;
      if (u_if.edit_field !== 1'b1) begin
         n_err++;
         $display("FAIL wrap_field: got %b want 1", u_if.edit_field);
      end
      for (int i = 1; i <= 2; i++) begin
         press(B_NEXT, 20);
         tot += g_on + g_off + g_man;
         n_cmp++;
         if (u_if.timer_select !== 2'(i)) begin
            n_err++;
            $display("FAIL wrap_timer%0d: got %0d want %0d", i,
                     u_if.timer_select, i);
         end
      end
      n_cmp++;
      if (tot !== 0) begin
         n_err++;
         $display("FAIL wrap_no_cmd: got %0d pulses want 0", tot);
      end
   endtask

   task automatic test_lock();
      do_reset();
      press(B_NEXT, 20);
      press(B_NEXT, 20);
      press(B_START, 20);
      n_cmp++;
      if (g_on !== 1 || g_selpulse !== 0 || u_if.fragrance_select !== 2'd2)
      begin
         n_err++;
         $display("FAIL lock_start: on=%0d selviol=%0d frag=%0d want 1 0 2",
                  g_on, g_selpulse, u_if.fragrance_select);
      end
      press(B_NEXT, 20);
      press(B_FIELD, 20);
      n_cmp++;
      if ({u_if.fragrance_select, u_if.timer_select, u_if.edit_field}
          !== {2'd2, 2'd0, 1'b0}) begin
         n_err++;
         $display("FAIL lock_sel: got f=%0d t=%0d e=%b want 2 0 0",
                  u_if.fragrance_select, u_if.timer_select,
                  u_if.edit_field);
      end
      press(B_START, 20);
      n_cmp++;
      if (g_on + g_off + g_man !== 0 || u_if.running !== 1'b1) begin
         n_err++;
         $display("FAIL lock_restart: pulses=%0d running=%b want 0 1",
                  g_on + g_off + g_man, u_if.running);
      end
   endtask

   task automatic test_manual_stop();
      press(B_MAN, 20);
      n_cmp++;
      if (g_man !== 1 || g_on + g_off !== 0 || u_if.running !== 1'b1) begin
         n_err++;
         $display("FAIL run_manual: man=%0d other=%0d run=%b want 1 0 1",
                  g_man, g_on + g_off, u_if.running);
      end
      press(B_STOP, 20);
      n_cmp++;
      if (g_off !== 1 || g_lat !== LAT || u_if.running !== 1'b0) begin
         n_err++;
         $display("FAIL run_stop: off=%0d lat=%0d run=%b want 1 %0d 0",
                  g_off, g_lat, u_if.running, LAT);
      end
      press(B_STOP, 20);
      n_cmp++;
      if (g_off !== 1 || u_if.running !== 1'b0) begin
         n_err++;
         $display("FAIL idle_stop: off=%0d run=%b want 1 0",
                  g_off, u_if.running);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      press(B_START, 20);
      press(B_START | B_STOP, 20);
      n_cmp++;
      if (g_off !== 1 || g_on !== 0 || u_if.running !== 1'b0) begin
         n_err++;
         $display("FAIL simul_stop: off=%0d on=%0d run=%b want 1 0 0",
                  g_off, g_on, u_if.running);
      end
      press(B_NEXT, 20);
      press(B_MAN | B_NEXT, 20);
      n_cmp++;
      if (g_man !== 1 || g_on + g_off !== 0
          || u_if.fragrance_select !== 2'd1) begin
         n_err++;
         $display("FAIL simul_manual: man=%0d other=%0d frag=%0d want 1 0 1",
                  g_man, g_on + g_off, u_if.fragrance_select);
      end
   endtask

   task automatic test_reset_mid();
      int lat, cnt;
      do_reset();
      press(B_FIELD, 20);
      press(B_NEXT, 20);
      press(B_NEXT, 20);
      press(B_START, 20);
      n_cmp++;
      if (u_if.timer_select !== 2'd2 || u_if.running !== 1'b1) begin
         n_err++;
         $display("FAIL mid_setup: timer=%0d run=%b want 2 1",
                  u_if.timer_select, u_if.running);
      end
      @(negedge clk);
      set_btn(B_STOP);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({u_if.fragrance_select, u_if.timer_select, u_if.edit_field,
           u_if.running, u_if.pump_on, u_if.pump_off, u_if.manual_on}
          !== 9'b0) begin
         n_err++;
         $display("FAIL mid_async: t=%0d e=%b r=%b off=%b want all 0",
                  u_if.timer_select, u_if.edit_field, u_if.running,
                  u_if.pump_off);
      end
      @(negedge clk);
      rst_n = 1'b1;
      lat = -1;
      cnt = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (u_if.pump_off) begin
            cnt++;
            if (lat < 0) lat = c;
         end
      end
      n_cmp++;
      if (cnt !== 1 || lat !== LAT) begin
         n_err++;
         $display("FAIL mid_held_stop: count=%0d lat=%0d want 1 %0d",
                  cnt, lat, LAT);
      end
      set_btn(5'b0);
      repeat (12) @(negedge clk);
   endtask

   task automatic test_random();
      logic [1:0] m_frag, m_tim;
      bit m_field, m_run;
      int e_on, e_off, e_man, hold;
      logic [4:0] m;
      do_reset();
      m_frag = 0; m_tim = 0; m_field = 0; m_run = 0;
      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(0, 3) == 0) m = 5'($urandom_range(1, 31));
         else m = 5'(1 << $urandom_range(0, 4));
         hold = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 4)
              : $urandom_range(5, 20);
         e_on = 0; e_off = 0; e_man = 0;
         if (hold >= 5) begin
            if (m[3]) begin
               e_off = 1;
               m_run = 0;
            end else if (m[2]) begin
               if (!m_run) begin
                  e_on = 1;
                  m_run = 1;
               end
            end else if (m[4]) begin
               e_man = 1;
            end else if (m[1]) begin
               if (!m_run) m_field = !m_field;
            end else if (m[0] && !m_run) begin
               if (m_field) m_tim = 2'((int'(m_tim) + 1) % 3);
               else m_frag = 2'((int'(m_frag) + 1) % 3);
            end
         end
         press(m, hold);
         n_cmp++;
         if (g_on !== e_on || g_off !== e_off || g_man !== e_man) begin
            n_err++;
            $display("FAIL rnd%0d_cmd m=%b h=%0d: got %0d%0d%0d want %0d%0d%0d",
                     it, m, hold, g_on, g_off, g_man, e_on, e_off, e_man);
         end
         if (e_on + e_off + e_man > 0) begin
            n_cmp++;
            if (g_lat !== LAT) begin
               n_err++;
               $display("FAIL rnd%0d_lat: got %0d want %0d", it, g_lat, LAT);
            end
         end
         n_cmp++;
         if ({u_if.fragrance_select, u_if.timer_select,
              u_if.edit_field, u_if.running}
             !== {m_frag, m_tim, m_field, m_run}) begin
            n_err++;
            $display("FAIL rnd%0d_state: got f%0d t%0d e%b r%b want f%0d t%0d e%b r%b",
                     it, u_if.fragrance_select, u_if.timer_select,
                     u_if.edit_field, u_if.running,
                     m_frag, m_tim, m_field, m_run);
         end
         n_cmp++;
         if (g_multi !== 0 || g_selpulse !== 0) begin
            n_err++;
            $display("FAIL rnd%0d_excl: multi=%0d selviol=%0d want 0 0",
                     it, g_multi, g_selpulse);
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      set_btn(5'b0);
      test_reset();
      test_debounce();
      test_wrap();
      test_lock();
      test_manual_stop();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end
endmodule
